// File: rtl/serializer_pattern_gen.sv
// Parallel-word source for the serializer: emits a burst of WORD_COUNT words
// from a selectable pattern, each with a one-cycle send strobe and an idle gap.
module serializer_pattern_gen #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    GAP_CYCLES = 10,
  parameter int                    WORD_COUNT = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(8'hB8)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [1:0]                         mode,
  input  logic [DATA_WIDTH-1:0]              seed,
  input  logic                               ready,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               send,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(WORD_COUNT+1)-1:0]    word_idx
);

  localparam int IDX_W = $clog2(WORD_COUNT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {M_CNT, M_LFSR, M_WALK, M_CONST} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_FIN} state_e;

  state_e                state;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] pat;
  logic [GAP_W-1:0]      gap_cnt;

  function automatic logic [DATA_WIDTH-1:0] advance(input mode_e m, input logic [DATA_WIDTH-1:0] p);
    logic [DATA_WIDTH-1:0] r;
    r = p;
    case (m)
      M_CNT:   r = p + DATA_WIDTH'(1);
      M_LFSR:  r = p[0] ? ((p >> 1) ^ LFSR_POLY) : (p >> 1);
      M_WALK:  r = {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      default: r = p;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= M_CNT;
      pat      <= '0;
      gap_cnt  <= '0;
      data     <= '0;
      send     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_idx <= '0;
    end else begin
      send <= 1'b0;
      done <= 1'b0;
      // abort beats ready and start, but only once a burst is underway
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
            if (start && !abort) begin
              mode_q   <= mode_e'(mode);
              // an all-zero LFSR would lock up, so seed it with 1 instead
              pat      <= (mode_e'(mode) == M_LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
              word_idx <= '0;
              busy     <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (ready) begin
              send     <= 1'b1;
              data     <= pat;
              pat      <= advance(mode_q, pat);
              word_idx <= word_idx + IDX_W'(1);
              gap_cnt  <= '0;
              if (word_idx == IDX_LAST)  state <= S_FIN;
              else if (GAP_CYCLES == 0)  state <= S_ISSUE;
              else                       state <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) state <= S_ISSUE;
            else                     gap_cnt <= gap_cnt + GAP_W'(1);
          end
          S_FIN: begin
            // busy stays up through the done cycle and drops from IDLE
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serializer_pattern_gen.sv
// Bench for serializer_pattern_gen: a GAP=10 and a GAP=0 instance checked
// against table vectors and a cycle-level model of the burst rules.
module tb_serializer_pattern_gen;
  localparam int GAP = 10;
  localparam int WC  = 4;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] seed = '0;

  logic [7:0] data_a, data_b;
  logic       send_a, send_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] idx_a, idx_b;

  logic       sel_b = 1'b0;
  logic [7:0] o_data;
  logic       o_send, o_busy, o_done;
  logic [2:0] o_idx;

  int n_vec = 0, n_bad = 0;
  logic [7:0] got_w [4];
  int         got_e [4];
  int         got_n;

  typedef struct {
    bit             b;
    logic [1:0]     m;
    logic [7:0]     s;
    logic [0:3][7:0] w;
    int             sp;
  } vec_t;
  vec_t tbl [7];

  serializer_pattern_gen #(.DATA_WIDTH(8), .GAP_CYCLES(GAP), .WORD_COUNT(WC), .LFSR_POLY(8'hB8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed), .ready(ready),
    .data(data_a), .send(send_a), .busy(busy_a), .done(done_a), .word_idx(idx_a));

  serializer_pattern_gen #(.DATA_WIDTH(8), .GAP_CYCLES(0), .WORD_COUNT(WC), .LFSR_POLY(8'hB8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed), .ready(ready),
    .data(data_b), .send(send_b), .busy(busy_b), .done(done_b), .word_idx(idx_b));

  always #5 clk = ~clk;

  always_comb begin
    o_data = sel_b ? data_b : data_a;
    o_send = sel_b ? send_b : send_a;
    o_busy = sel_b ? busy_b : busy_a;
    o_done = sel_b ? done_b : done_a;
    o_idx  = sel_b ? idx_b  : idx_a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // i-th word of a burst, straight from the pattern definitions
  function automatic logic [7:0] model_word(input logic [1:0] m, input logic [7:0] s, input int i);
    logic [7:0]  p;
    logic [15:0] w;
    case (m)
      2'd0: return s + 8'(i);
      2'd2: begin w = {s, s} << (i % 8); return w[15:8]; end
      2'd3: return s;
      default: begin
        p = (s == 8'h00) ? 8'h01 : s;
        repeat (i) p = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
        return p;
      end
    endcase
  endfunction

  // rkind: 0 ready high, 1 random ready, 2 ready low for 5 edges at 2nd issue
  task automatic burst(input bit b, input logic [1:0] m, input logic [7:0] s,
                       input int rkind, input int ab_edge, input bit rnd_start);
    int gap, earliest, last, stop, npulse;
    bit aborted, rdy, finished;
    logic [7:0] e_data;
    logic       e_send, e_busy, e_done;
    logic [2:0] e_idx;
    gap = b ? 0 : GAP;
    do_reset();
    sel_b = b;
    e_data = '0; e_send = 0; e_busy = 0; e_done = 0; e_idx = '0;
    npulse = 0; got_n = 0; earliest = 1; last = -10; stop = -1;
    aborted = 0; finished = 0;
    for (int i = 0; i < 4; i++) begin got_w[i] = '0; got_e[i] = -1; end
    for (int n = 0; n < 400; n++) begin
      case (rkind)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(n >= gap + 2 && n < gap + 7);
      endcase
      ready = rdy;
      start = (n == 0) || (rnd_start && !aborted && npulse < WC && $urandom_range(0, 3) == 0);
      abort = (n == ab_edge);
      mode  = (n == 0) ? m : 2'($urandom);
      seed  = (n == 0) ? s : 8'($urandom);
      e_send = 0; e_done = 0;
      if (aborted) begin end
      else if (n == 0) begin e_busy = 1; e_idx = '0; end
      else if (abort && (npulse < WC || n == last + 1)) begin
        aborted = 1; e_busy = 0; stop = n + 2;
      end
      else if (npulse < WC) begin
        if (n >= earliest && rdy) begin
          e_send = 1; e_data = model_word(m, s, npulse);
          npulse++; e_idx = 3'(npulse); earliest = n + gap + 1;
          if (npulse == WC) last = n;
        end
      end
      else if (n == last + 1) e_done = 1;
      else begin e_busy = 0; if (stop < 0) stop = n + 1; end
      step();
      chk($sformatf("send@%0d", n), 32'(o_send), 32'(e_send));
      chk($sformatf("data@%0d", n), 32'(o_data), 32'(e_data));
      chk($sformatf("busy@%0d", n), 32'(o_busy), 32'(e_busy));
      chk($sformatf("done@%0d", n), 32'(o_done), 32'(e_done));
      chk($sformatf("word_idx@%0d", n), 32'(o_idx), 32'(e_idx));
      if (o_send && got_n < 4) begin got_w[got_n] = o_data; got_e[got_n] = n; got_n++; end
      if (stop >= 0 && n >= stop) begin finished = 1; break; end
    end
    start = 0; abort = 0;
    if (!finished) begin
      n_vec++; n_bad++;
      $display("FAIL burst_timeout: burst still running after 400 cycles, expected completion");
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'd0, 8'hFE, {8'hFE, 8'hFF, 8'h00, 8'h01}, 11};
    tbl[1] = '{1'b0, 2'd1, 8'h01, {8'h01, 8'hB8, 8'h5C, 8'h2E}, 11};
    tbl[2] = '{1'b0, 2'd1, 8'h00, {8'h01, 8'hB8, 8'h5C, 8'h2E}, 11};
    tbl[3] = '{1'b0, 2'd2, 8'h81, {8'h81, 8'h03, 8'h06, 8'h0C}, 11};
    tbl[4] = '{1'b0, 2'd3, 8'h5A, {8'h5A, 8'h5A, 8'h5A, 8'h5A}, 11};
    tbl[5] = '{1'b1, 2'd0, 8'hFE, {8'hFE, 8'hFF, 8'h00, 8'h01}, 1};
    tbl[6] = '{1'b1, 2'd1, 8'h01, {8'h01, 8'hB8, 8'h5C, 8'h2E}, 1};

    // reset state
    do_reset();
    chk("rst_data_a", 32'(data_a), 0); chk("rst_send_a", 32'(send_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0); chk("rst_done_a", 32'(done_a), 0);
    chk("rst_idx_a",  32'(idx_a),  0);
    chk("rst_data_b", 32'(data_b), 0); chk("rst_send_b", 32'(send_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0); chk("rst_done_b", 32'(done_b), 0);
    chk("rst_idx_b",  32'(idx_b),  0);

    // pattern table
    for (int t = 0; t < 7; t++) begin
      burst(tbl[t].b, tbl[t].m, tbl[t].s, 0, -1, 0);
      chk($sformatf("tbl%0d_count", t), 32'(got_n), 4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d_word%0d", t, i), 32'(got_w[i]), 32'(tbl[t].w[i]));
      chk($sformatf("tbl%0d_spacing", t), 32'(got_e[1] - got_e[0]), 32'(tbl[t].sp));
      chk($sformatf("tbl%0d_spacing_last", t), 32'(got_e[3] - got_e[2]), 32'(tbl[t].sp));
    end

    // ready stall at the second issue
    burst(0, 2'd0, 8'hFE, 2, -1, 0);
    chk("stall_count", 32'(got_n), 4);
    chk("stall_edge2", 32'(got_e[1]), 17);
    chk("stall_word2", 32'(got_w[1]), 32'h00FF);

    // abort during the gap after word 2, and abort racing sends
    burst(0, 2'd0, 8'hFE, 0, 15, 0);
    chk("abort_gap_count", 32'(got_n), 2);
    burst(1, 2'd0, 8'h10, 0, 3, 0);
    chk("abort_issue_count", 32'(got_n), 2);
    burst(1, 2'd0, 8'h10, 0, 4, 0);
    chk("abort_final_count", 32'(got_n), 3);

    // abort alone and abort+start in IDLE
    do_reset(); sel_b = 0;
    abort = 1; step();
    chk("idle_abort_busy", 32'(busy_a), 0);
    chk("idle_abort_send", 32'(send_a), 0);
    start = 1; abort = 1; step();
    chk("start_abort_busy", 32'(busy_a), 0);
    abort = 0; start = 1; mode = 2'd0; seed = 8'h33; step();
    chk("start_busy", 32'(busy_a), 1);
    start = 0; ready = 1; step();
    chk("start_send", 32'(send_a), 1);
    chk("start_data", 32'(data_a), 32'h33);

    // asynchronous reset in the middle of a burst
    do_reset(); sel_b = 0;
    start = 1; mode = 2'd0; seed = 8'hFE; ready = 1; step();
    start = 0; step();
    chk("pre_rst_send", 32'(send_a), 1);
    chk("pre_rst_data", 32'(data_a), 32'hFE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(data_a), 0);
    chk("async_rst_send", 32'(send_a), 0);
    chk("async_rst_busy", 32'(busy_a), 0);
    chk("async_rst_idx",  32'(idx_a),  0);
    @(negedge clk); rst_n = 1'b1;
    burst(0, 2'd0, 8'hFE, 0, -1, 0);
    chk("post_rst_count", 32'(got_n), 4);
    chk("post_rst_last",  32'(got_w[3]), 32'h01);

    // randomized bursts against the model
    for (int r = 0; r < 24; r++) begin
      burst(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 1,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/serializer_pattern_gen.md
Name: serializer_pattern_gen

Overview:
Synthesizable, parametrised parallel-word source that drives the serializer's data/send inputs in hardware. It generates a burst of WORD_COUNT words from a selectable pattern (counter, LFSR, walking-one, constant). Each word is issued with a one-cycle send strobe, followed by a programmable idle gap. Adds what the bench stimulus lacked: a ready handshake, abort, busy/done status, and pattern modes.

Parameters:
DATA_WIDTH, 8, width of generated word (>=2)
GAP_CYCLES, 10, minimum idle cycles (send low) between consecutive send pulses; 0 allowed
WORD_COUNT, 16, words per burst (>=1)
LFSR_POLY, 8'hB8, Galois LFSR tap mask, DATA_WIDTH bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  begin burst; sampled only in IDLE
abort  input  1  terminate burst, return to IDLE
mode  input  2  0 counter, 1 LFSR, 2 walking-one, 3 constant; latched at start
seed  input  DATA_WIDTH  first word; latched at start
ready  input  1  serializer can accept a word
data  output  DATA_WIDTH  current word; held stable between send pulses
send  output  1  one-cycle strobe, data valid
busy  output  1  burst in progress
done  output  1  one-cycle pulse at normal burst completion
word_idx  output  clog2(WORD_COUNT+1)  words sent in current burst

Behaviour:
- Reset (async, rst_n=0): state IDLE; data=0, send=0, busy=0, done=0, word_idx=0; gap counter and latched mode/seed cleared. Reset mid-burst discards the burst, no done.
- All outputs registered.
- States: IDLE, ISSUE, GAP, FIN.
- IDLE: start=1 at edge k -> latch mode/seed, pattern reg=seed (LFSR mode with seed 0 loads 1), word_idx=0, busy=1 after edge k, go ISSUE.
- ISSUE: at an edge with ready=1 -> send=1 for the following cycle, data=pattern reg, word_idx+1, pattern advances. Next state is GAP, or FIN if word_idx reaches WORD_COUNT. With ready=0 the block stays in ISSUE, send=0, data holds.
- First send is therefore high in the cycle after edge k+1 when ready=1.
- GAP: send=0; counts GAP_CYCLES cycles, then ISSUE. With GAP_CYCLES=0, GAP is skipped: ISSUE->ISSUE, and send stays high on consecutive cycles while ready=1.
- FIN: the cycle after the last send pulse. done=1 for exactly that cycle, busy=0 the following cycle, state IDLE. No trailing gap. data keeps the last word. word_idx holds WORD_COUNT until the next start.
- Pattern advance, modulo 2^DATA_WIDTH:
  - counter: +1, wraps all-ones -> 0
  - LFSR: lsb=1 -> (p>>1)^LFSR_POLY, else p>>1
  - walking-one: rotate left by 1
  - constant: unchanged
- abort=1 in any non-IDLE state: next edge -> IDLE, send=0, busy=0, done=0. abort has priority over ready and over a simultaneous final send. abort in IDLE has no effect.
- start while busy: ignored. start and abort both high in IDLE: abort wins, start ignored.
- ready is only sampled in ISSUE. ready dropping during GAP does not extend the gap; it only stalls the next ISSUE.
- Inter-pulse spacing with ready held high: exactly GAP_CYCLES low cycles.

Test Plan:
1. DATA_WIDTH=8, GAP=10, WORD_COUNT=4, mode 0, seed 0xFE, ready=1 -> data FE,FF,00,01. Pulses 11 cycles apart. done 1 cycle after 4th pulse. word_idx=4.
2. Mode 1, LFSR_POLY 0xB8, seed 0x01 -> 01,B8,5C,2E. Seed 0x00 -> first word 0x01.
3. Mode 2, seed 0x81 -> 81,03,06,0C. Mode 3, seed 0x5A -> four 5A words.
4. ready low for 5 cycles at 2nd ISSUE -> send held off, data stable. Pulse fires on the first edge ready=1. Total pulses still 4.
5. GAP_CYCLES=0, ready=1 -> send high 4 consecutive cycles with FE,FF,00,01, done next cycle.
6. abort asserted in GAP after word 2 -> IDLE next cycle, no done, busy=0. Then rst_n low mid-burst -> all outputs 0 immediately (asynchronous). A new start then works normally.
